// File: rtl/pipe_stage_buf.sv
// Parametrised pipeline-stage register with valid/ready handshakes, synchronous flush and a stall counter.
// Define PIPE_STAGE_SKID_EN to build the two-entry skid variant, where in_ready comes straight from a flop.
module pipe_stage_buf #(
  parameter int WIDTH          = 32,
  parameter bit CLEAR_ON_FLUSH = 1'b1,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt,
  input  logic             stall_clr
);

  logic in_v;
  logic out_r;
  logic up_acc;

  // X or Z on a handshake input resolves to 1 in simulation; item order makes a Z match the 1 arm
  always_comb begin
    in_v = 1'b1;
    casez (in_valid)
      1'b1:    in_v = 1'b1;
      1'b0:    in_v = 1'b0;
      default: in_v = 1'b1;
    endcase
  end

  always_comb begin
    out_r = 1'b1;
    casez (out_ready)
      1'b1:    out_r = 1'b1;
      1'b0:    out_r = 1'b0;
      default: out_r = 1'b1;
    endcase
  end

  assign up_acc = in_v && in_ready;

`ifdef PIPE_STAGE_SKID_EN
  typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             rdy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      rdy_q   <= (state_d != SKID);
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      if (CLEAR_ON_FLUSH) begin
        main_d = '0;
        skid_d = '0;
      end
    end else begin
      case (state_q)
        EMPTY: begin
          if (up_acc) begin
            state_d = FULL;
            main_d  = in_data;
          end
        end
        FULL: begin
          if (up_acc && !out_r) begin
            state_d = SKID;
            skid_d  = in_data;
          end else if (up_acc) begin
            main_d = in_data;
          end else if (out_r) begin
            state_d = EMPTY;
          end
        end
        SKID: begin
          // older payload leaves first; the skid entry then becomes the head
          if (out_r) begin
            state_d = FULL;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;

  always_comb begin
    occupancy = 2'd0;
    case (state_q)
      FULL:    occupancy = 2'd1;
      SKID:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end
`else
  logic             valid_q;
  logic [WIDTH-1:0] data_q;

  assign in_ready = !valid_q || out_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
      if (CLEAR_ON_FLUSH) data_q <= '0;
    end else if (up_acc) begin
      valid_q <= 1'b1;
      data_q  <= in_data;
    end else if (valid_q && out_r) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign occupancy = {1'b0, valid_q};
`endif

  // counts cycles where the head payload is blocked downstream; a flush cycle is not a stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall_clr) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_r && !flush && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
